zube_wb_mailbox: RTL and testbench

Wishbone-slave mailbox that sits directly behind the Caravel Wishbone port inside the Zube wrapper and feeds the external-bus interface logic. It holds two byte FIFOs: to_ext (management SoC -> external CPU) and from_ext (external CPU -> management SoC). It also provides status and interrupt-enable registers, and drives the data-ready and status interrupt lines.

---
 rtl/zube_mailbox_pkg.sv | 23 ++
 rtl/zube_wb_mailbox_if.sv | 22 ++
 rtl/zube_byte_fifo.sv | 60 ++++++
 rtl/zube_wb_mailbox.sv | 159 +++++++++++++++
 tb/tb_zube_wb_mailbox.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/zube_mailbox_pkg.sv
// rtl/zube_mailbox_pkg.sv - register map and bit indices for the Zube Wishbone mailbox
// Purpose: shared constants for zube_wb_mailbox (register offsets, STATUS and IRQ_EN bit positions).
// Ports: none (package).
package zube_mailbox_pkg;

    // Register byte offsets within the 256-byte window
    localparam logic [7:0] REG_DATA   = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h04;
    localparam logic [7:0] REG_IRQ_EN = 8'h08;
    localparam logic [7:0] REG_LEVELS = 8'h0C;

    // STATUS bit positions
    localparam int ST_FROM_NE  = 0;
    localparam int ST_TO_FULL  = 1;
    localparam int ST_OVF      = 2;
    localparam int ST_DROP     = 3;
    localparam int ST_TO_EMPTY = 4;

    // IRQ_EN bit positions
    localparam int IRQ_DATA   = 0;
    localparam int IRQ_STATUS = 1;

endpackage

// File: rtl/zube_wb_mailbox_if.sv
// rtl/zube_wb_mailbox_if.sv - Wishbone slave bus bundle for the Zube mailbox
// Purpose: groups the Wishbone request/response signals.
// Ports: master drives cyc/stb/we/addr/data_in and samples ack/data_out; slave is the reverse.
interface zube_wb_mailbox_if;
    logic        wb_cyc_in;
    logic        wb_stb_in;
    logic        wb_we_in;
    logic [31:0] wb_addr_in;
    logic [31:0] wb_data_in;
    logic        wb_ack_out;
    logic [31:0] wb_data_out;

    modport master (
        output wb_cyc_in, wb_stb_in, wb_we_in, wb_addr_in, wb_data_in,
        input  wb_ack_out, wb_data_out
    );

    modport slave (
        input  wb_cyc_in, wb_stb_in, wb_we_in, wb_addr_in, wb_data_in,
        output wb_ack_out, wb_data_out
    );
endinterface

// File: rtl/zube_byte_fifo.sv
// rtl/zube_byte_fifo.sv - show-ahead byte FIFO used for both mailbox directions
// Purpose: DEPTH-entry byte FIFO; push while full is accepted only alongside a pop.
// Ports: clk, reset (sync, active-high), push/push_data, pop, head (0 when empty), empty, full, count.
module zube_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign empty = (r_count == '0);
    assign full  = (r_count == FULL_CNT);
    assign count = r_count;
    assign head  = empty ? 8'h00 : r_mem[r_rd_ptr];

    // A pop on an empty FIFO is ignored; a push on a full FIFO only fits if a pop frees the slot.
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/zube_wb_mailbox.sv
// rtl/zube_wb_mailbox.sv - Wishbone mailbox between the management SoC and the external CPU
// Purpose: two byte FIFOs (to_ext, from_ext) with DATA/STATUS/IRQ_EN/LEVELS registers and two IRQs.
// Ports: clk, reset (sync, active-high), wb (Wishbone slave), ext_wr_strobe/ext_wr_data (into from_ext),
//        ext_rd_strobe/ext_rd_data (out of to_ext), ext_tx_avail, ext_rx_space, irq_data_out, irq_status_out.
module zube_wb_mailbox
    import zube_mailbox_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    zube_wb_mailbox_if.slave        wb,
    input  logic                    ext_wr_strobe,
    input  logic [7:0]              ext_wr_data,
    input  logic                    ext_rd_strobe,
    output logic [7:0]              ext_rd_data,
    output logic                    ext_tx_avail,
    output logic                    ext_rx_space,
    output logic                    irq_data_out,
    output logic                    irq_status_out
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic       r_ack;
    logic       r_we;
    logic [7:0] r_off;
    logic [7:0] r_wdata;
    logic       r_ovf;
    logic       r_drop;
    logic [1:0] r_irq_en;
    logic       r_irq_data;
    logic       r_irq_status;

    logic          w_hit;
    logic          w_wr;
    logic          w_rd;
    logic          w_to_push;
    logic          w_from_pop;
    logic          w_stat_wr;
    logic          w_ovf_set;
    logic          w_drop_set;
    logic          w_ovf_clr;
    logic          w_drop_clr;
    logic [7:0]    w_to_head;
    logic [7:0]    w_from_head;
    logic          w_to_empty;
    logic          w_to_full;
    logic          w_from_empty;
    logic          w_from_full;
    logic [CW-1:0] w_to_count;
    logic [CW-1:0] w_from_count;
    logic [31:0]   w_rdata;
    logic          w_unused;

    assign w_unused = &{1'b0, wb.wb_data_in[31:8]};

    // The ack cycle blocks a new hit, so every access takes exactly two cycles.
    assign w_hit = wb.wb_cyc_in & wb.wb_stb_in & ~r_ack
                 & (wb.wb_addr_in[31:8] == BASE_ADDR[31:8]);

    // Side effects happen in the ack cycle, using the request latched at the hit.
    assign w_wr       = r_ack & r_we;
    assign w_rd       = r_ack & ~r_we;
    assign w_to_push  = w_wr & (r_off == REG_DATA);
    assign w_from_pop = w_rd & (r_off == REG_DATA) & ~w_from_empty;
    assign w_stat_wr  = w_wr & (r_off == REG_STATUS);

    // A push into a full FIFO is only an error when no pop frees a slot in the same cycle.
    assign w_ovf_set  = ext_wr_strobe & w_from_full & ~w_from_pop;
    assign w_drop_set = w_to_push & w_to_full & ~ext_rd_strobe;
    assign w_ovf_clr  = w_stat_wr & r_wdata[ST_OVF];
    assign w_drop_clr = w_stat_wr & r_wdata[ST_DROP];

    zube_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_to_ext (
        .clk       (clk),
        .reset     (reset),
        .push      (w_to_push),
        .push_data (r_wdata),
        .pop       (ext_rd_strobe),
        .head      (w_to_head),
        .empty     (w_to_empty),
        .full      (w_to_full),
        .count     (w_to_count)
    );

    zube_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_from_ext (
        .clk       (clk),
        .reset     (reset),
        .push      (ext_wr_strobe),
        .push_data (ext_wr_data),
        .pop       (w_from_pop),
        .head      (w_from_head),
        .empty     (w_from_empty),
        .full      (w_from_full),
        .count     (w_from_count)
    );

    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            case (r_off)
                REG_DATA: begin
                    if (!w_from_empty) w_rdata = {23'b0, 1'b1, w_from_head};
                end
                REG_STATUS: begin
                    w_rdata[ST_FROM_NE]  = ~w_from_empty;
                    w_rdata[ST_TO_FULL]  = w_to_full;
                    w_rdata[ST_OVF]      = r_ovf;
                    w_rdata[ST_DROP]     = r_drop;
                    w_rdata[ST_TO_EMPTY] = w_to_empty;
                end
                REG_IRQ_EN: w_rdata[1:0] = r_irq_en;
                REG_LEVELS: begin
                    w_rdata[7:0]  = 8'(w_from_count);
                    w_rdata[15:8] = 8'(w_to_count);
                end
                default: w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack        <= 1'b0;
            r_we         <= 1'b0;
            r_off        <= '0;
            r_wdata      <= '0;
            r_ovf        <= 1'b0;
            r_drop       <= 1'b0;
            r_irq_en     <= '0;
            r_irq_data   <= 1'b0;
            r_irq_status <= 1'b0;
        end else begin
            r_ack <= w_hit;
            if (w_hit) begin
                r_we    <= wb.wb_we_in;
                r_off   <= wb.wb_addr_in[7:0];
                r_wdata <= wb.wb_data_in[7:0];
            end
            // Set beats a same-cycle W1C clear.
            r_ovf  <= w_ovf_set  | (r_ovf  & ~w_ovf_clr);
            r_drop <= w_drop_set | (r_drop & ~w_drop_clr);
            if (w_wr && (r_off == REG_IRQ_EN)) r_irq_en <= r_wdata[1:0];
            r_irq_data   <= r_irq_en[IRQ_DATA]   & ~w_from_empty;
            r_irq_status <= r_irq_en[IRQ_STATUS] & (r_ovf | r_drop);
        end
    end

    assign wb.wb_ack_out  = r_ack;
    assign wb.wb_data_out = w_rdata;
    assign ext_rd_data    = w_to_head;
    assign ext_tx_avail   = ~w_to_empty;
    assign ext_rx_space   = ~w_from_full;
    assign irq_data_out   = r_irq_data;
    assign irq_status_out = r_irq_status;

endmodule

// File: tb/tb_zube_wb_mailbox.sv
// tb/tb_zube_wb_mailbox.sv - self-checking bench for zube_wb_mailbox
module tb_zube_wb_mailbox;

    localparam logic [31:0] B = 32'h3000_0000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ext_wr_strobe = 1'b0;
    logic [7:0] ext_wr_data = 8'h00;
    logic       ext_rd_strobe = 1'b0;
    logic [7:0] ext_rd_data;
    logic       ext_tx_avail;
    logic       ext_rx_space;
    logic       irq_data_out;
    logic       irq_status_out;

    zube_wb_mailbox_if bus ();

    zube_wb_mailbox #(.BASE_ADDR(B), .FIFO_DEPTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .wb             (bus),
        .ext_wr_strobe  (ext_wr_strobe),
        .ext_wr_data    (ext_wr_data),
        .ext_rd_strobe  (ext_rd_strobe),
        .ext_rd_data    (ext_rd_data),
        .ext_tx_avail   (ext_tx_avail),
        .ext_rx_space   (ext_rx_space),
        .irq_data_out   (irq_data_out),
        .irq_status_out (irq_status_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        exp_ack;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // One Wishbone access; returns at the negedge of the expected ack cycle.
    task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                           output logic ack, output logic [31:0] rd);
        @(posedge clk);
        #1;
        bus.wb_cyc_in = 1'b1; bus.wb_stb_in = 1'b1; bus.wb_we_in = w;
        bus.wb_addr_in = a;   bus.wb_data_in = d;
        @(negedge clk);
        check("early_ack", bus.wb_ack_out, 0);
        @(posedge clk);
        @(negedge clk);
        ack = bus.wb_ack_out;
        rd  = bus.wb_data_out;
        bus.wb_cyc_in = 1'b0; bus.wb_stb_in = 1'b0; bus.wb_we_in = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        logic        ack;
        logic [31:0] rd;
        wb_xfer(a, 1'b1, d, ack, rd);
        check("wr_ack", ack, 1);
    endtask

    task automatic wb_read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic        ack;
        logic [31:0] rd;
        wb_xfer(a, 1'b0, 32'h0, ack, rd);
        check({name, "_ack"}, ack, 1);
        check(name, rd, exp);
    endtask

    // Wishbone write whose ack cycle coincides with an external strobe.
    task automatic wb_write_with_ext(input logic [31:0] a, input logic [31:0] d,
                                     input logic wr_s, input logic rd_s, input logic [7:0] wr_d);
        @(posedge clk);
        #1;
        bus.wb_cyc_in = 1'b1; bus.wb_stb_in = 1'b1; bus.wb_we_in = 1'b1;
        bus.wb_addr_in = a;   bus.wb_data_in = d;
        @(posedge clk);
        #1;
        bus.wb_cyc_in = 1'b0; bus.wb_stb_in = 1'b0; bus.wb_we_in = 1'b0;
        check("ext_sync_ack", bus.wb_ack_out, 1);
        ext_wr_strobe = wr_s; ext_rd_strobe = rd_s; ext_wr_data = wr_d;
        @(posedge clk);
        #1;
        ext_wr_strobe = 1'b0; ext_rd_strobe = 1'b0;
        @(negedge clk);
    endtask

    task automatic ext_wr_pulse(input logic [7:0] d);
        @(posedge clk);
        #1;
        ext_wr_strobe = 1'b1; ext_wr_data = d;
        @(posedge clk);
        #1;
        ext_wr_strobe = 1'b0;
        @(negedge clk);
    endtask

    task automatic ext_rd_pulse();
        @(posedge clk);
        #1;
        ext_rd_strobe = 1'b1;
        @(posedge clk);
        #1;
        ext_rd_strobe = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_q[$];
        logic       ack;
        logic [31:0] rd;

        vecs[0]  = '{B + 32'h04,  1'b0, 32'h0,         1'b1, 32'h0000_0010};
        vecs[1]  = '{B + 32'h0C,  1'b0, 32'h0,         1'b1, 32'h0000_0000};
        vecs[2]  = '{B + 32'h08,  1'b1, 32'h3,         1'b1, 32'h0};
        vecs[3]  = '{B + 32'h08,  1'b0, 32'h0,         1'b1, 32'h0000_0003};
        vecs[4]  = '{B + 32'h08,  1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0};
        vecs[5]  = '{B + 32'h08,  1'b0, 32'h0,         1'b1, 32'h0000_0000};
        vecs[6]  = '{B + 32'h20,  1'b0, 32'h0,         1'b1, 32'h0000_0000};
        vecs[7]  = '{B + 32'h20,  1'b1, 32'hFF,        1'b1, 32'h0};
        vecs[8]  = '{B + 32'h100, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[9]  = '{32'h4000_0004, 1'b1, 32'h41,      1'b0, 32'h0};
        vecs[10] = '{B + 32'h00,  1'b0, 32'h0,         1'b1, 32'h0000_0000};
        vecs[11] = '{B + 32'h04,  1'b0, 32'h0,         1'b1, 32'h0000_0010};

        bus.wb_cyc_in = 1'b0; bus.wb_stb_in = 1'b0; bus.wb_we_in = 1'b0;
        bus.wb_addr_in = '0;  bus.wb_data_in = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ack", bus.wb_ack_out, 0);
        check("rst_data", bus.wb_data_out, 0);
        check("rst_rd_data", ext_rd_data, 0);
        check("rst_tx_avail", ext_tx_avail, 0);
        check("rst_rx_space", ext_rx_space, 1);
        check("rst_irq_data", irq_data_out, 0);
        check("rst_irq_status", irq_status_out, 0);

        // Register / decode vectors
        for (int i = 0; i < 12; i++) begin
            wb_xfer(vecs[i].addr, vecs[i].we, vecs[i].wdata, ack, rd);
            check($sformatf("vec%0d_ack", i), ack, vecs[i].exp_ack);
            if (!vecs[i].we) check($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
        end
        check("vec_irq_data", irq_data_out, 0);
        check("vec_irq_status", irq_status_out, 0);

        // to_ext path
        wb_write(B, 32'h41);
        wb_write(B, 32'h42);
        wb_read_chk("levels_2", B + 32'h0C, 32'h0000_0200);
        check("tx_avail_2", ext_tx_avail, 1);
        check("rd_head_41", ext_rd_data, 8'h41);
        ext_rd_pulse();
        check("rd_head_42", ext_rd_data, 8'h42);
        check("tx_avail_1", ext_tx_avail, 1);
        ext_rd_pulse();
        check("tx_avail_0", ext_tx_avail, 0);
        check("rd_head_empty", ext_rd_data, 0);
        wb_read_chk("levels_0", B + 32'h0C, 32'h0);
        ext_rd_pulse();
        wb_read_chk("status_empty_pop", B + 32'h04, 32'h10);

        // from_ext overflow, status IRQ, W1C
        wb_write(B, 32'h77);
        for (int i = 0; i < 9; i++) begin
            ext_wr_pulse(8'(i));
            if (i == 7) check("rx_space_full", ext_rx_space, 0);
        end
        wb_read_chk("status_ovf", B + 32'h04, 32'h05);
        check("irq_status_off", irq_status_out, 0);
        wb_write(B + 32'h08, 32'h2);
        tick(2);
        check("irq_status_on", irq_status_out, 1);
        check("irq_data_masked", irq_data_out, 0);
        wb_write(B + 32'h04, 32'h4);
        tick(2);
        check("irq_status_clr", irq_status_out, 0);
        wb_read_chk("status_ovf_clr", B + 32'h04, 32'h01);
        wb_read_chk("levels_1_8", B + 32'h0C, 32'h0000_0108);
        for (int i = 0; i < 8; i++)
            wb_read_chk($sformatf("drain%0d", i), B, 32'h100 | 32'(i));
        wb_read_chk("drain_empty", B, 32'h0);
        wb_read_chk("status_to1", B + 32'h04, 32'h00);

        // Data IRQ
        wb_write(B + 32'h08, 32'h1);
        ext_wr_pulse(8'h5A);
        check("irq_data_latency", irq_data_out, 0);
        tick(1);
        check("irq_data_on", irq_data_out, 1);
        wb_read_chk("data_5a", B, 32'h0000_015A);
        wb_read_chk("data_none", B, 32'h0);
        tick(1);
        check("irq_data_off", irq_data_out, 0);

        // Full to_ext with simultaneous push and pop
        exp_q.delete();
        for (int i = 0; i < 7; i++) begin
            wb_write(B, 32'h10 + 32'(i));
            exp_q.push_back(8'h10 + 8'(i));
        end
        wb_read_chk("status_full", B + 32'h04, 32'h02);
        wb_write_with_ext(B, 32'h99, 1'b0, 1'b1, 8'h00);
        exp_q.push_back(8'h99);
        wb_read_chk("status_full_nodrop", B + 32'h04, 32'h02);
        wb_read_chk("levels_8", B + 32'h0C, 32'h0000_0800);
        foreach (exp_q[i]) begin
            check($sformatf("to_ext_order%0d", i), ext_rd_data, exp_q[i]);
            ext_rd_pulse();
        end
        check("to_ext_drained", ext_tx_avail, 0);

        // DROP on full to_ext, then W1C
        for (int i = 0; i < 9; i++) wb_write(B, 32'h20 + 32'(i));
        wb_read_chk("status_drop", B + 32'h04, 32'h0A);
        wb_write(B + 32'h04, 32'h8);
        wb_read_chk("status_drop_clr", B + 32'h04, 32'h02);

        // OVF set and W1C clear in the same cycle: set wins
        for (int i = 0; i < 9; i++) ext_wr_pulse(8'hC0 + 8'(i));
        wb_write_with_ext(B + 32'h04, 32'h4, 1'b1, 1'b0, 8'hEE);
        wb_read_chk("status_set_wins", B + 32'h04, 32'h07);
        wb_write(B + 32'h04, 32'h4);
        wb_read_chk("status_ovf_clr2", B + 32'h04, 32'h03);

        // Reset during a pending ack
        wb_write(B + 32'h08, 32'h3);
        tick(2);
        check("pre_rst_irq_data", irq_data_out, 1);
        @(posedge clk);
        #1;
        bus.wb_cyc_in = 1'b1; bus.wb_stb_in = 1'b1; bus.wb_we_in = 1'b1;
        bus.wb_addr_in = B;   bus.wb_data_in = 32'h55;
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.wb_cyc_in = 1'b0; bus.wb_stb_in = 1'b0; bus.wb_we_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_ack", bus.wb_ack_out, 0);
        check("mid_rst_tx_avail", ext_tx_avail, 0);
        check("mid_rst_rx_space", ext_rx_space, 1);
        check("mid_rst_rd_data", ext_rd_data, 0);
        check("mid_rst_irq_data", irq_data_out, 0);
        check("mid_rst_irq_status", irq_status_out, 0);
        #1 reset = 1'b0;
        wb_read_chk("post_rst_status", B + 32'h04, 32'h10);
        wb_read_chk("post_rst_irq_en", B + 32'h08, 32'h0);
        wb_read_chk("post_rst_levels", B + 32'h0C, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
